// File: rtl/slc3_io_responder.sv
`default_nettype none
// ============================================================================
// Module  : slc3_io_responder
// Brief   : Memory-mapped switch/hex I/O port with debounced Run/Continue pulses.
// Revision: 1.0 - initial release
// ============================================================================
module slc3_io_responder #(
    parameter logic [15:0] IO_ADDR   = 16'hFFFF,
    parameter int          DB_CYCLES = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  SW,
    input  logic        Run,
    input  logic        Continue,
    input  logic [15:0] ADDR,
    input  logic        MEM_REQ,
    input  logic        WE,
    input  logic [15:0] DATA_IN,
    output logic [15:0] DATA_OUT,
    output logic        READY,
    output logic        RUN_PULSE,
    output logic        CONT_PULSE,
    output logic [9:0]  LED,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3
);

    localparam int                c_cw       = $clog2(DB_CYCLES + 1);
    localparam logic [c_cw-1:0]   c_cnt_last = c_cw'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      r_state;
    logic [9:0]  r_sw_s1;
    logic [9:0]  r_sw_s2;
    logic        r_we;
    logic [15:0] r_wdata;
    logic [15:0] r_hex_reg;
    logic [15:0] r_dout;
    logic        r_ready;
    logic [1:0]  w_btn_raw;
    logic [1:0]  w_btn_pulse;

    function automatic logic [6:0] f_seg(input logic [3:0] n);
        case (n)
            4'h0: f_seg = 7'h40;
            4'h1: f_seg = 7'h79;
            4'h2: f_seg = 7'h24;
            4'h3: f_seg = 7'h30;
            4'h4: f_seg = 7'h19;
            4'h5: f_seg = 7'h12;
            4'h6: f_seg = 7'h02;
            4'h7: f_seg = 7'h78;
            4'h8: f_seg = 7'h00;
            4'h9: f_seg = 7'h10;
            4'hA: f_seg = 7'h08;
            4'hB: f_seg = 7'h03;
            4'hC: f_seg = 7'h46;
            4'hD: f_seg = 7'h21;
            4'hE: f_seg = 7'h06;
            default: f_seg = 7'h0E;
        endcase
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
        end else begin
            r_sw_s1 <= SW;
            r_sw_s2 <= r_sw_s1;
        end
    end

    // Bus request fields are captured at acceptance so later bus changes are ignored.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_hex_reg <= '0;
            r_dout    <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b0;
                    r_dout  <= '0;
                    if (MEM_REQ && (ADDR == IO_ADDR)) begin
                        r_we    <= WE;
                        r_wdata <= DATA_IN;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_we) begin
                        r_hex_reg <= r_wdata;
                        r_dout    <= '0;
                    end else begin
                        r_dout    <= {6'b0, r_sw_s2};
                    end
                    r_ready <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_ready <= 1'b0;
                    r_dout  <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_dout  <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_btn_raw = {Continue, Run};

    // Index 0 is Run, index 1 is Continue; both are active-low and idle high.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic            r_s1;
            logic            r_s2;
            logic            r_db;
            logic            r_pulse;
            logic [c_cw-1:0] r_cnt;

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    r_s1    <= 1'b1;
                    r_s2    <= 1'b1;
                    r_db    <= 1'b1;
                    r_pulse <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_s1    <= w_btn_raw[gi];
                    r_s2    <= r_s1;
                    r_pulse <= 1'b0;
                    if (r_s2 == r_db) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_cnt   <= '0;
                        r_db    <= r_s2;
                        r_pulse <= ~r_s2;
                    end else begin
                        r_cnt <= r_cnt + c_cw'(1);
                    end
                end
            end

            assign w_btn_pulse[gi] = r_pulse;
        end
    endgenerate

    assign RUN_PULSE  = w_btn_pulse[0];
    assign CONT_PULSE = w_btn_pulse[1];
    assign READY      = r_ready;
    assign DATA_OUT   = r_dout;
    assign LED        = r_hex_reg[9:0];
    assign HEX0       = f_seg(r_hex_reg[3:0]);
    assign HEX1       = f_seg(r_hex_reg[7:4]);
    assign HEX2       = f_seg(r_hex_reg[11:8]);
    assign HEX3       = f_seg(r_hex_reg[15:12]);

endmodule
`default_nettype wire

// File: doc/slc3_io_responder.md
SLC3_IO_RESPONDER -- requirements
Module: slc3_io_responder

Interface
REQ-001 Parameter IO_ADDR, default 16'hFFFF, the single bus address decoded as the switch/hex I/O port.
REQ-002 Parameter DB_CYCLES, default 4, the number of consecutive stable synchronized samples needed to accept a button level change.
REQ-003 Clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 SW  input  10  raw slide switches, asynchronous.
REQ-006 Run  input  1  raw pushbutton, active-low (0 = pressed), asynchronous.
REQ-007 Continue  input  1  raw pushbutton, active-low (0 = pressed), asynchronous.
REQ-008 ADDR  input  16  CPU bus address.
REQ-009 MEM_REQ  input  1  CPU access request, held high until READY is seen.
REQ-010 WE  input  1  1 = write and 0 = read, sampled with MEM_REQ.
REQ-011 DATA_IN  input  16  CPU write data.
REQ-012 DATA_OUT  output  16  read data, valid while READY=1.
REQ-013 READY  output  1  one-cycle access-complete strobe.
REQ-014 RUN_PULSE  output  1  one-cycle strobe per debounced Run press.
REQ-015 CONT_PULSE  output  1  one-cycle strobe per debounced Continue press.
REQ-016 LED  output  10  hex_reg[9:0].
REQ-017 HEX0..HEX3  output  7 each  active-low 7-seg for hex_reg nibbles [3:0]..[15:12], bit6=g ... bit0=a.

Function
REQ-018 SW, Run and Continue SHALL each pass through a 2-flop synchronizer before any use; a switch change is visible in read data no earlier than 2 cycles after it occurs.
REQ-019 Each button SHALL have a debounce counter that resets on any synchronized-sample change and updates the debounced level only after DB_CYCLES identical consecutive samples.
REQ-020 RUN_PULSE / CONT_PULSE SHALL be high for exactly one cycle on each debounced 1->0 transition, never held by a long press, with no pulse on release.
REQ-021 The bus FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-022 IDLE->ACCESS when MEM_REQ=1 and ADDR==IO_ADDR, with ADDR, WE and DATA_IN captured on that edge; any other address is ignored, READY stays 0 and DATA_OUT stays 0.
REQ-023 ACCESS->DONE unconditionally; on this edge a write loads hex_reg from captured data, and a read loads DATA_OUT={6'b0, SW_sync}.
REQ-024 In DONE, READY=1 for exactly one cycle, 2 cycles after the accepting edge, and the FSM returns to IDLE.
REQ-025 DATA_OUT SHALL hold the read value through the READY cycle, return to 0 in IDLE, and be 0 for writes.
REQ-026 A new request SHALL be accepted no earlier than the cycle after DONE, so a held MEM_REQ produces at most one access per 3 cycles.
REQ-027 If MEM_REQ drops in ACCESS, the access still completes; captured values are used and later bus changes are ignored.
REQ-028 Button pulses SHALL be independent of bus activity; simultaneous Run and Continue presses each produce their own pulse in the same cycle.
REQ-029 7-seg encoding SHALL be active-low hex 0-F (0=7'h40, 1=7'h79, 8=7'h00, A=7'h08, F=7'h0E), decoded combinationally from hex_reg.

Reset
REQ-030 While Reset=1, the FSM SHALL go to IDLE, hex_reg=0 (HEX*=7'h40, LED=0), READY=0, DATA_OUT=0, pulses=0, debounced levels=1 (released), and counters=0.
REQ-031 Reset asserted during ACCESS or DONE SHALL abort the access with no READY and no hex_reg update.
REQ-032 A button held pressed through reset release SHALL produce exactly one pulse after DB_CYCLES+2 cycles.

Verification
REQ-033 Write: ADDR=FFFF, WE=1, DATA_IN=16'h12AF, MEM_REQ held -> READY 1 cycle at accept+2; HEX3..0=79,24,08,0E; LED=10'h2AF.
REQ-034 Read: SW=10'h033, wait 3 cycles, read FFFF -> DATA_OUT=16'h0033 during READY.
REQ-035 ADDR=FFFE, MEM_REQ=1 for 10 cycles -> READY never asserts and hex_reg is unchanged.
REQ-036 Run low for 2 cycles, then high, then low for 20 cycles (DB_CYCLES=4) -> no pulse on the glitch, exactly one RUN_PULSE, and none on release.
REQ-037 Reset pulse in the ACCESS cycle of a write of 16'hBEEF -> no READY, hex_reg=0, and the next request completes normally.
